irq_sequencer: RTL

//  Interrupt entry/exit sequencer for the 5-stage pipeline. Latches requests from the

---
 rtl/irq_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: interrupt entry/exit sequencer for the 5-stage core.
// Ports: clk, reset (async, active-high); irq_req/irq_en per source;
//   if_pc, stall, ctrl_in_flt from the pipeline; take_irq, vector_pc,
//   epc_we, epc_addr, epc_data, irq_ack, irq_cause, in_handler out.
module irq_sequencer #(
   parameter int          NUM_SRC   = 3,
   parameter logic [31:0] VECTOR_PC = 32'h8000_0004,
   parameter logic [4:0]  EPC_REG   = 5'd26,
   localparam int         CW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_req,
   input  logic [NUM_SRC-1:0] irq_en,
   input  logic [31:0]        if_pc,
   input  logic               stall,
   input  logic               ctrl_in_flt,
   output logic               take_irq,
   output logic [31:0]        vector_pc,
   output logic               epc_we,
   output logic [4:0]         epc_addr,
   output logic [31:0]        epc_data,
   output logic [NUM_SRC-1:0] irq_ack,
   output logic [CW-1:0]      irq_cause,
   output logic               in_handler
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SAFE,
      ENTER,
      HANDLER
   } state_t;

   state_t             state, state_n;
   logic [NUM_SRC-1:0] req_q;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] win_oh;
   logic [CW-1:0]      win_idx;
   logic [CW-1:0]      cause_q;
   logic               any_pend;
   logic               found;
   logic               fire;
   logic               exit_hdl;

   assign vector_pc = VECTOR_PC;
   assign epc_addr  = EPC_REG;

   assign rise     = irq_req & ~req_q;
   assign any_pend = |pending;

   // Fixed priority: lowest pending index wins.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (pending[i] && !found) begin
            win_oh[i] = 1'b1;
            win_idx   = CW'(i);
            found     = 1'b1;
         end
      end
   end

   // The entry pulse is the safe cycle itself, so epc_data is the PC
   // that IF holds while it is being squashed.
   assign fire     = (state == WAIT_SAFE) && any_pend
                     && !stall && !ctrl_in_flt;
   assign exit_hdl = (state == HANDLER) && !if_pc[31];

   always_comb begin
      state_n    = state;
      take_irq   = 1'b0;
      epc_we     = 1'b0;
      epc_data   = '0;
      irq_ack    = '0;
      irq_cause  = cause_q;
      in_handler = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_pend && !if_pc[31])
               state_n = WAIT_SAFE;
         end
         WAIT_SAFE: begin
            if (!any_pend) begin
               state_n = IDLE;
            end else if (fire) begin
               take_irq   = 1'b1;
               epc_we     = 1'b1;
               epc_data   = if_pc;
               irq_ack    = win_oh;
               irq_cause  = win_idx;
               in_handler = 1'b1;
               state_n    = ENTER;
            end
         end
         // One cycle for the vector fetch to reach IF before the
         // kernel bit is trusted for exit detection.
         ENTER: begin
            in_handler = 1'b1;
            state_n    = HANDLER;
         end
         HANDLER: begin
            in_handler = 1'b1;
            if (!if_pc[31])
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         req_q   <= '0;
         pending <= '0;
         cause_q <= '0;
      end else begin
         state <= state_n;
         req_q <= irq_req;
         // New edge beats the ack; disabling a source drops it.
         pending <= ((pending & ~irq_ack) | rise) & irq_en;
         if (fire)
            cause_q <= win_idx;
         else if (exit_hdl)
            cause_q <= '0;
      end
   end

endmodule
